// File: rtl/fifo_checker.sv
// fifo_checker: self-checking consumer for a FIFO under test.
// Keeps a shadow queue of accepted writes, compares every popped word and
// the empty/full flags against it, and reports sticky error status plus
// saturating error and transaction counters.

// Saturating up-counter used for every statistics/error count.
module fifo_checker_sat_cnt #(
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          reset_i,
  input  logic          inc_i,
  output logic [CW-1:0] cnt_o
);

  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [CW-1:0] CNT_MAX = '1;

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Next count: step by one unless already pinned at the maximum.
  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_ONE;
    end
  end

  // Count register, cleared immediately on reset.
  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

module fifo_checker #(
  parameter int B  = 8,
  parameter int W  = 4,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          rd,
  input  logic          wr,
  input  logic [B-1:0]  w_data,
  input  logic [B-1:0]  r_data,
  input  logic          empty,
  input  logic          full,
  output logic          err,
  output logic [CW-1:0] data_err_cnt,
  output logic [CW-1:0] flag_err_cnt,
  output logic [CW-1:0] wr_cnt,
  output logic [CW-1:0] rd_cnt,
  output logic [W:0]    level,
  output logic [B-1:0]  exp_data
);

  localparam int            DEPTH      = 2 ** W;
  localparam logic [W:0]    FULL_LEVEL = {1'b1, {W{1'b0}}};
  localparam logic [W:0]    LEVEL_ONE  = (W+1)'(1);
  localparam logic [W-1:0]  PTR_ONE    = W'(1);
  localparam int            NUM_CNT    = 4;

  typedef enum logic [1:0] {
    ST_INIT = 2'd0,
    ST_RUN  = 2'd1,
    ST_FAIL = 2'd2
  } state_t;

  state_t state_q;
  logic   err_q;

  // Shadow queue storage and bookkeeping.
  logic [B-1:0] mem_q [DEPTH];
  logic [W-1:0] wr_ptr_q;
  logic [W-1:0] wr_ptr_d;
  logic [W-1:0] rd_ptr_q;
  logic [W-1:0] rd_ptr_d;
  logic [W:0]   level_q;
  logic [W:0]   level_d;

  logic model_empty;
  logic model_full;
  logic push;
  logic pop;
  logic check_en;
  logic data_mismatch;
  logic flag_mismatch;
  logic any_mismatch;
  logic [B-1:0] head_word;

  logic [NUM_CNT-1:0] cnt_inc;
  logic [CW-1:0]      cnt_val [NUM_CNT];

  assign model_empty = (level_q == '0);
  assign model_full  = (level_q == FULL_LEVEL);

  // The model only accepts what a correct FIFO would: rd on an empty model
  // and wr on a full model are dropped, so rd&wr at the extremes collapse
  // to a single push or a single pop.
  assign push = wr & ~model_full;
  assign pop  = rd & ~model_empty;

  assign head_word = mem_q[rd_ptr_q];

  // Nothing is compared in the first cycle after reset release.
  assign check_en = (state_q != ST_INIT);

  // Popped word is compared against the model head in the same cycle.
  assign data_mismatch = check_en & pop & (r_data != head_word);

  // Either flag disagreeing counts as one flag error for the cycle.
  assign flag_mismatch = check_en &
                         ((empty != model_empty) | (full != model_full));

  assign any_mismatch = data_mismatch | flag_mismatch;

  // Next pointer/occupancy state from the model's own push/pop decisions;
  // the DUT flags never feed back into the model.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
    case ({push, pop})
      2'b10:   level_d = level_q + LEVEL_ONE;
      2'b01:   level_d = level_q - LEVEL_ONE;
      default: level_d = level_q;
    endcase
  end

  // Pointer and occupancy registers; occupancy drops to zero on reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Model storage: write the tail on push; contents need no reset because
  // the head is masked whenever the model is empty.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= w_data;
    end
  end

  // Checker FSM: INIT for one cycle, then RUN until the first failed check,
  // then FAIL with err held until reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_INIT;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_INIT: begin
          state_q <= ST_RUN;
        end
        ST_RUN: begin
          if (any_mismatch) begin
            state_q <= ST_FAIL;
            err_q   <= 1'b1;
          end
        end
        ST_FAIL: begin
          state_q <= ST_FAIL;
          err_q   <= 1'b1;
        end
        default: begin
          state_q <= ST_INIT;
          err_q   <= 1'b0;
        end
      endcase
    end
  end

  // Counter increments: data errors, flag errors, pushes, pops.
  assign cnt_inc = {pop, push, flag_mismatch, data_mismatch};

  generate
    for (genvar gi = 0; gi < NUM_CNT; gi++) begin : g_cnt
      fifo_checker_sat_cnt #(
        .CW(CW)
      ) u_cnt (
        .clk     (clk),
        .reset_i (reset),
        .inc_i   (cnt_inc[gi]),
        .cnt_o   (cnt_val[gi])
      );
    end
  endgenerate

  assign data_err_cnt = cnt_val[0];
  assign flag_err_cnt = cnt_val[1];
  assign wr_cnt       = cnt_val[2];
  assign rd_cnt       = cnt_val[3];

  assign err      = err_q;
  assign level    = level_q;
  assign exp_data = model_empty ? '0 : head_word;

endmodule

// File: tb/tb_fifo_checker.sv
// Directed bench for fifo_checker with B=3, W=2 (DEPTH=4), CW=4 so that
// counter saturation is reachable in a short run.
module tb_fifo_checker;

  localparam int B  = 3;
  localparam int W  = 2;
  localparam int CW = 4;

  logic          clk;
  logic          reset;
  logic          rd;
  logic          wr;
  logic [B-1:0]  w_data;
  logic [B-1:0]  r_data;
  logic          empty;
  logic          full;
  logic          err;
  logic [CW-1:0] data_err_cnt;
  logic [CW-1:0] flag_err_cnt;
  logic [CW-1:0] wr_cnt;
  logic [CW-1:0] rd_cnt;
  logic [W:0]    level;
  logic [B-1:0]  exp_data;

  int tests;
  int failures;

  typedef struct {
    logic rd;
    logic wr;
    int   wd;
    int   rdat;
    logic emp;
    logic ful;
    logic e_err;
    int   e_dec;
    int   e_fec;
    int   e_wc;
    int   e_rc;
    int   e_lvl;
    int   e_exp;
  } vec_t;

  vec_t t1 [27];
  vec_t t2 [8];

  fifo_checker #(
    .B (B),
    .W (W),
    .CW(CW)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .rd          (rd),
    .wr          (wr),
    .w_data      (w_data),
    .r_data      (r_data),
    .empty       (empty),
    .full        (full),
    .err         (err),
    .data_err_cnt(data_err_cnt),
    .flag_err_cnt(flag_err_cnt),
    .wr_cnt      (wr_cnt),
    .rd_cnt      (rd_cnt),
    .level       (level),
    .exp_data    (exp_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input logic rd_v, input logic wr_v, input int wd,
                              input int rdat, input logic emp, input logic ful,
                              input logic e_err, input int e_dec, input int e_fec,
                              input int e_wc, input int e_rc, input int e_lvl,
                              input int e_exp);
    vec_t v;
    v.rd = rd_v; v.wr = wr_v; v.wd = wd; v.rdat = rdat; v.emp = emp; v.ful = ful;
    v.e_err = e_err; v.e_dec = e_dec; v.e_fec = e_fec; v.e_wc = e_wc;
    v.e_rc = e_rc; v.e_lvl = e_lvl; v.e_exp = e_exp;
    return v;
  endfunction

  task automatic check(input string name, input logic e_err, input int e_dec,
                       input int e_fec, input int e_wc, input int e_rc,
                       input int e_lvl, input int e_exp);
    tests++;
    if (err !== e_err || data_err_cnt !== CW'(e_dec) || flag_err_cnt !== CW'(e_fec) ||
        wr_cnt !== CW'(e_wc) || rd_cnt !== CW'(e_rc) || level !== (W+1)'(e_lvl) ||
        exp_data !== B'(e_exp)) begin
      failures++;
      $display("FAIL %s: got err=%0b dec=%0d fec=%0d wc=%0d rc=%0d lvl=%0d exp=%0d, want err=%0b dec=%0d fec=%0d wc=%0d rc=%0d lvl=%0d exp=%0d",
               name, err, data_err_cnt, flag_err_cnt, wr_cnt, rd_cnt, level, exp_data,
               e_err, e_dec, e_fec, e_wc, e_rc, e_lvl, e_exp);
    end else begin
      $display("[TB] %s ok: err=%0b dec=%0d fec=%0d wc=%0d rc=%0d lvl=%0d exp=%0d",
               name, err, data_err_cnt, flag_err_cnt, wr_cnt, rd_cnt, level, exp_data);
    end
  endtask

  task automatic apply(input vec_t v, input string name);
    rd     = v.rd;
    wr     = v.wr;
    w_data = B'(v.wd);
    r_data = B'(v.rdat);
    empty  = v.emp;
    full   = v.ful;
    @(posedge clk);
    #1;
    check(name, v.e_err, v.e_dec, v.e_fec, v.e_wc, v.e_rc, v.e_lvl, v.e_exp);
  endtask

  initial begin
    tests    = 0;
    failures = 0;

    //            rd wr wd rd_d emp ful | err dec fec wc rc lvl exp
    // Fill 1..4, idle at full, overflow attempt, drain, underflow attempt.
    t1[0]  = mk(0, 1, 1, 0, 1, 0,  0, 0, 0,  1,  0, 1, 1);
    t1[1]  = mk(0, 1, 2, 1, 0, 0,  0, 0, 0,  2,  0, 2, 1);
    t1[2]  = mk(0, 1, 3, 1, 0, 0,  0, 0, 0,  3,  0, 3, 1);
    t1[3]  = mk(0, 1, 4, 1, 0, 0,  0, 0, 0,  4,  0, 4, 1);
    t1[4]  = mk(0, 0, 0, 1, 0, 1,  0, 0, 0,  4,  0, 4, 1);
    t1[5]  = mk(0, 1, 5, 1, 0, 1,  0, 0, 0,  4,  0, 4, 1);
    t1[6]  = mk(1, 0, 0, 1, 0, 1,  0, 0, 0,  4,  1, 3, 2);
    t1[7]  = mk(1, 0, 0, 2, 0, 0,  0, 0, 0,  4,  2, 2, 3);
    t1[8]  = mk(1, 0, 0, 3, 0, 0,  0, 0, 0,  4,  3, 1, 4);
    t1[9]  = mk(1, 0, 0, 4, 0, 0,  0, 0, 0,  4,  4, 0, 0);
    t1[10] = mk(1, 0, 0, 0, 1, 0,  0, 0, 0,  4,  4, 0, 0);
    // rd&wr on empty model: push only. Then rd&wr at level 2 holding 5,6.
    t1[11] = mk(1, 1, 5, 0, 1, 0,  0, 0, 0,  5,  4, 1, 5);
    t1[12] = mk(0, 1, 6, 5, 0, 0,  0, 0, 0,  6,  4, 2, 5);
    t1[13] = mk(1, 1, 7, 5, 0, 0,  0, 0, 0,  7,  5, 2, 6);
    t1[14] = mk(1, 0, 0, 6, 0, 0,  0, 0, 0,  7,  6, 1, 7);
    t1[15] = mk(1, 0, 0, 7, 0, 0,  0, 0, 0,  7,  7, 0, 0);
    // Write 1,2,3 across the pointer wrap; second pop returns corrupted 0.
    t1[16] = mk(0, 1, 1, 0, 1, 0,  0, 0, 0,  8,  7, 1, 1);
    t1[17] = mk(0, 1, 2, 1, 0, 0,  0, 0, 0,  9,  7, 2, 1);
    t1[18] = mk(0, 1, 3, 1, 0, 0,  0, 0, 0, 10,  7, 3, 1);
    t1[19] = mk(1, 0, 0, 1, 0, 0,  0, 0, 0, 10,  8, 2, 2);
    t1[20] = mk(1, 0, 0, 0, 0, 0,  1, 1, 0, 10,  9, 1, 3);
    t1[21] = mk(1, 0, 0, 3, 0, 0,  1, 1, 0, 10, 10, 0, 0);
    t1[22] = mk(0, 1, 4, 0, 1, 0,  1, 1, 0, 11, 10, 1, 4);
    t1[23] = mk(1, 0, 0, 4, 0, 0,  1, 1, 0, 11, 11, 0, 0);
    // Clean traffic up to level 3 with err still latched.
    t1[24] = mk(0, 1, 5, 0, 1, 0,  1, 1, 0, 12, 11, 1, 5);
    t1[25] = mk(0, 1, 6, 5, 0, 0,  1, 1, 0, 13, 11, 2, 5);
    t1[26] = mk(0, 1, 7, 5, 0, 0,  1, 1, 0, 14, 11, 3, 5);

    // Flag errors after a fresh reset: empty stuck low, then both wrong,
    // then the model keeps its own occupancy while flags disagree.
    t2[0] = mk(0, 0, 0, 0, 0, 0,  1, 0, 1, 0, 0, 0, 0);
    t2[1] = mk(0, 0, 0, 0, 0, 0,  1, 0, 2, 0, 0, 0, 0);
    t2[2] = mk(0, 0, 0, 0, 0, 0,  1, 0, 3, 0, 0, 0, 0);
    t2[3] = mk(0, 0, 0, 0, 0, 1,  1, 0, 4, 0, 0, 0, 0);
    t2[4] = mk(0, 0, 0, 0, 1, 0,  1, 0, 4, 0, 0, 0, 0);
    t2[5] = mk(0, 1, 2, 0, 1, 0,  1, 0, 4, 1, 0, 1, 2);
    t2[6] = mk(0, 0, 0, 2, 1, 0,  1, 0, 5, 1, 0, 1, 2);
    t2[7] = mk(1, 0, 0, 2, 0, 0,  1, 0, 5, 1, 1, 0, 0);

    reset  = 1'b1;
    rd     = 1'b0;
    wr     = 1'b0;
    w_data = '0;
    r_data = '0;
    empty  = 1'b1;
    full   = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    check("reset_state", 0, 0, 0, 0, 0, 0, 0);
    reset = 1'b0;

    for (int i = 0; i < 27; i++) begin
      apply(t1[i], $sformatf("t1[%0d]", i));
    end

    // Asynchronous reset between edges at level 3 with err set.
    #2;
    reset = 1'b1;
    #1;
    check("async_reset", 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    // Release with a bogus empty flag: the INIT cycle must not count it.
    rd     = 1'b0;
    wr     = 1'b0;
    empty  = 1'b0;
    full   = 1'b0;
    reset  = 1'b0;
    @(posedge clk);
    #1;
    check("init_suppressed", 0, 0, 0, 0, 0, 0, 0);

    for (int i = 0; i < 8; i++) begin
      apply(t2[i], $sformatf("t2[%0d]", i));
    end

    // Flag errors continue until the counter pins at its maximum.
    rd    = 1'b0;
    wr    = 1'b0;
    empty = 1'b0;
    full  = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    check("flag_cnt_14", 1, 0, 14, 1, 1, 0, 0);
    repeat (3) @(posedge clk);
    #1;
    check("flag_cnt_saturated", 1, 0, 15, 1, 1, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule

// File: doc/fifo_checker.md
Name: fifo_checker

Overview:
- Synthesizable self-checking consumer for the fifo block. It sits on the read side of the FIFO under test, next to the stimulus generator and the passive monitor.
- Keeps a shadow queue (reference model) of accepted writes. Compares every popped r_data and the empty/full flags against that model.
- Exposes sticky error status, error counters and transaction counts, so benches and on-board self-tests get a pass/fail without waveform inspection.

Parameters:
- B, 8, data word width in bits (must match the FIFO under test).
- W, 4, address width; model depth DEPTH = 2**W (must match the FIFO under test).
- CW, 16, width of every statistics/error counter.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- rd  input  1  read request seen by the FIFO.
- wr  input  1  write request seen by the FIFO.
- w_data  input  B  write data seen by the FIFO.
- r_data  input  B  FIFO read data (combinational head of queue).
- empty  input  1  FIFO empty flag.
- full  input  1  FIFO full flag.
- err  output  1  sticky: any mismatch since reset.
- data_err_cnt  output  CW  count of r_data mismatches.
- flag_err_cnt  output  CW  count of cycles with an empty/full mismatch.
- wr_cnt  output  CW  accepted writes (model push count).
- rd_cnt  output  CW  accepted reads (model pop count).
- level  output  W+1  model occupancy, 0..DEPTH.
- exp_data  output  B  model head word; 0 when level==0.

Behaviour:
- Reset (async, active-high):
  - All outputs 0; level=0; state=INIT.
  - Model array contents are don't-care.
- FSM states:
  - INIT: first cycle after reset release. Model updates, checks suppressed. Moves to RUN next cycle.
  - RUN: model updates and all checks enabled. Moves to FAIL on the cycle any check fails.
  - FAIL: same as RUN, and err held at 1. Leaves FAIL only on reset.
- Model push/pop rules:
  - push = wr & (level<DEPTH).
  - pop = rd & (level>0).
  - Both can happen in the same cycle.
  - Pop reads the head at the cycle edge; push writes at the tail.
  - level += push - pop.
- Boundary cases:
  - level==0 with rd&wr: push only; rd ignored.
  - level==DEPTH with rd&wr: pop only; wr ignored.
  - Pointers wrap modulo DEPTH with no gap.
- Data check (RUN/FAIL), on a cycle with pop:
  - Compare r_data with exp_data in that same cycle.
  - On inequality: data_err_cnt +1 and err=1 at the next edge.
- Flag check (RUN/FAIL), every cycle:
  - Mismatch if empty != (level==0) OR full != (level==DEPTH).
  - On mismatch: flag_err_cnt +1 for that cycle (one increment even if both flags are wrong); err=1 at the next edge.
- Flag check is independent of the model:
  - The model never follows the DUT flags.
  - After a flag error the model continues on its own push/pop rules, so later divergence keeps being reported.
- Counters:
  - wr_cnt/rd_cnt increment on push/pop.
  - All counters saturate at 2**CW-1; no wrap.
- Latency: status outputs are registered; one cycle after the causing event. exp_data and level reflect the current model state.
- Reset mid-operation: everything returns to reset values immediately (async), including the model level. No checking in the first cycle after release.

Test Plan (B=3, W=2, DEPTH=4):
- Sequential fill/drain: write 1,2,3,4 with a correct FIFO -> full=1 matches at level 4. Read 4 -> r_data 1,2,3,4; err=0; wr_cnt=rd_cnt=4; level=0.
- Simultaneous rd&wr at level 2 (holding 5,6), writing 7 -> r_data=5; level stays 2; exp_data=6 next cycle; no errors.
- Overflow/underflow attempts:
  - wr at level 4 -> wr_cnt unchanged, level 4.
  - rd at level 0 -> rd_cnt unchanged.
  - rd&wr at level 0 -> push only, level 1.
  - err=0 throughout.
- Corrupted data: force r_data=0 on the second pop of 1,2,3 -> data_err_cnt=1 and err=1 the next cycle. state=FAIL; err stays 1 through later clean traffic.
- Flag error: hold empty=0 for 3 cycles while level=0 -> flag_err_cnt=3 and err=1. A wrong empty and a wrong full in the same cycle count once.
- Async reset at level 3 with err=1 -> all outputs 0 immediately. The first post-release cycle with a bogus flag is not counted (INIT).
